// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, reset PC and word-alignment mask.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_fetch_controller_adder.sv
// Constant-increment PC adder; wraps modulo 2^WIDTH with no carry out.
module pc_fetch_controller_adder #(
  parameter int WIDTH = 32,
  parameter int INC   = 4
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + WIDTH'(INC);

endmodule

// File: rtl/pc_fetch_controller.sv
// Program counter owner: selects sequential/branch/jump next PC under stall and imem back-pressure.
//   state | meaning
//   BOOT  | one idle cycle after reset, no fetch, redirects ignored
//   RUN   | fetching, PC advances on each accepted fetch
//   HOLD  | fetch stalled (hazard or imem not ready), PC held
module pc_fetch_controller
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_INC   = 4,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             imem_ready,
  output logic [31:0]      pc,
  output logic [31:0]      pcp4,
  output logic             fetch_req,
  output logic             fetch_valid,
  output logic             if_flush,
  output logic             misalign,
  output logic             hold,
  output logic [CNT_W-1:0] stall_cycles
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect;
  logic [31:0]      target;

  pc_fetch_controller_adder #(
    .WIDTH (32),
    .INC   (PC_INC)
  ) u_pcp4 (
    .a_i   (pc_q),
    .sum_o (pcp4)
  );

  // Jump wins over a simultaneous taken branch.
  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = 1'b0;
    fetch_req   = 1'b0;
    fetch_valid = 1'b0;
    if_flush    = 1'b0;
    hold        = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_HOLD: begin
        fetch_req = 1'b1;
        hold      = (state_q == ST_HOLD);
        if (redirect) begin
          pc_d       = target & WORD_ALIGN_MASK;
          if_flush   = 1'b1;
          misalign_d = (target[1:0] != 2'b00);
          state_d    = ST_RUN;
        end else if (stall || !imem_ready) begin
          state_d = ST_HOLD;
        end else begin
          pc_d        = pcp4;
          fetch_valid = 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign cnt_d = ((state_q == ST_HOLD) && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign misalign     = misalign_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Self-checking bench for pc_fetch_controller: per-cycle vector table plus reset and saturation sequences.
module tb_pc_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, imem_ready = 1'b1;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] pc, pcp4;
  logic        fetch_req, fetch_valid, if_flush, misalign, hold;
  logic [15:0] stall_cycles;

  logic [31:0] s_pc, s_pcp4;
  logic        s_fetch_req, s_fetch_valid, s_if_flush, s_misalign, s_hold;
  logic [2:0]  s_stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_ready(imem_ready), .pc(pc), .pcp4(pcp4), .fetch_req(fetch_req),
    .fetch_valid(fetch_valid), .if_flush(if_flush), .misalign(misalign),
    .hold(hold), .stall_cycles(stall_cycles)
  );

  pc_fetch_controller #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_ready(imem_ready), .pc(s_pc), .pcp4(s_pcp4), .fetch_req(s_fetch_req),
    .fetch_valid(s_fetch_valid), .if_flush(s_if_flush), .misalign(s_misalign),
    .hold(s_hold), .stall_cycles(s_stall_cycles)
  );

  typedef struct {
    bit          stall, br, jmp, rdy;
    logic [31:0] bt, jt;
    logic [31:0] pc;
    bit          freq, fval, flush, hold, mis;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic add(input bit st, input bit br, input logic [31:0] bt, input bit jm,
                     input logic [31:0] jt, input bit rdy, input logic [31:0] epc,
                     input bit efreq, input bit efval, input bit efl, input bit ehold,
                     input bit emis, input logic [15:0] ecnt);
    vec_t v;
    v.stall = st; v.br = br; v.bt = bt; v.jmp = jm; v.jt = jt; v.rdy = rdy;
    v.pc = epc; v.freq = efreq; v.fval = efval; v.flush = efl; v.hold = ehold;
    v.mis = emis; v.cnt = ecnt;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    // Redirect during BOOT must be ignored.
    add(0,1,32'h80,0,0,1,            32'h0,       0,0,0,0,0,0);
    add(0,0,0,0,0,1,                 32'h0,       1,1,0,0,0,0);
    add(0,0,0,0,0,1,                 32'h4,       1,1,0,0,0,0);
    add(0,0,0,0,0,1,                 32'h8,       1,1,0,0,0,0);
    add(0,0,0,0,0,1,                 32'hC,       1,1,0,0,0,0);
    // Two stall cycles, one imem back-pressure cycle.
    add(1,0,0,0,0,1,                 32'h10,      1,0,0,0,0,0);
    add(1,0,0,0,0,1,                 32'h10,      1,0,0,1,0,0);
    add(0,0,0,0,0,0,                 32'h10,      1,0,0,1,0,1);
    add(0,0,0,0,0,1,                 32'h10,      1,1,0,1,0,2);
    add(0,0,0,0,0,1,                 32'h14,      1,1,0,0,0,3);
    add(0,0,0,0,0,1,                 32'h18,      1,1,0,0,0,3);
    add(0,0,0,0,0,1,                 32'h1C,      1,1,0,0,0,3);
    // Jump beats branch, stall and imem_ready=0.
    add(1,1,32'h100,1,32'h200,0,     32'h20,      1,0,1,0,0,3);
    add(0,0,0,0,0,1,                 32'h200,     1,1,0,0,0,3);
    add(0,1,32'h43,0,0,1,            32'h204,     1,0,1,0,0,3);
    add(0,0,0,0,0,1,                 32'h40,      1,1,0,0,1,3);
    add(0,0,0,0,0,1,                 32'h44,      1,1,0,0,0,3);
    // Misaligned jump taken out of HOLD, landing near the top of memory.
    add(1,0,0,0,0,1,                 32'h48,      1,0,0,0,0,3);
    add(1,0,0,1,32'hFFFF_FFFA,1,     32'h48,      1,0,1,1,0,3);
    add(0,0,0,0,0,1,                 32'hFFFF_FFF8,1,1,0,0,1,4);
    add(0,0,0,0,0,1,                 32'hFFFF_FFFC,1,1,0,0,0,4);
    add(0,0,0,0,0,1,                 32'h0,       1,1,0,0,0,4);
    add(0,0,0,1,32'h30,1,            32'h4,       1,0,1,0,0,4);
    add(1,0,0,0,0,1,                 32'h30,      1,0,0,0,0,4);
    add(1,0,0,0,0,1,                 32'h30,      1,0,0,1,0,4);

    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_fetch_req", {31'b0, fetch_req}, 32'h0);
    check("rst_cnt", {16'b0, stall_cycles}, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      stall = tbl[i].stall; branch_taken = tbl[i].br; branch_target = tbl[i].bt;
      jump = tbl[i].jmp; jump_target = tbl[i].jt; imem_ready = tbl[i].rdy;
      exp_q.push_back(tbl[i]);
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty at row %0d", i);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("pc[%0d]", i), pc, e.pc);
        check($sformatf("pcp4[%0d]", i), pcp4, e.pc + 32'd4);
        check($sformatf("fetch_req[%0d]", i), {31'b0, fetch_req}, {31'b0, e.freq});
        check($sformatf("fetch_valid[%0d]", i), {31'b0, fetch_valid}, {31'b0, e.fval});
        check($sformatf("if_flush[%0d]", i), {31'b0, if_flush}, {31'b0, e.flush});
        check($sformatf("hold[%0d]", i), {31'b0, hold}, {31'b0, e.hold});
        check($sformatf("misalign[%0d]", i), {31'b0, misalign}, {31'b0, e.mis});
        check($sformatf("stall_cycles[%0d]", i), {16'b0, stall_cycles}, {16'b0, e.cnt});
      end
    end

    // Async reset while held at 0x30: must take effect with no clock edge.
    @(negedge clk);
    stall = 1'b1; branch_taken = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    #1;
    check("pre_rst_hold", {31'b0, hold}, 32'h1);
    check("pre_rst_cnt", {16'b0, stall_cycles}, 32'd5);
    check("pre_rst_pc", pc, 32'h30);
    #2 rst_n = 1'b0;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_cnt", {16'b0, stall_cycles}, 32'h0);
    check("async_fetch_req", {31'b0, fetch_req}, 32'h0);
    check("async_hold", {31'b0, hold}, 32'h0);
    check("async_flush", {31'b0, if_flush}, 32'h0);

    // Long stall after reset: 3-bit counter saturates, 16-bit keeps counting.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("sat_cnt3", {29'b0, s_stall_cycles}, 32'd7);
    check("long_cnt16", {16'b0, stall_cycles}, 32'd10);
    check("long_pc", pc, 32'h0);
    check("long_hold", {31'b0, hold}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
